// File: rtl/wb_block_reader_if.sv
// rtl/wb_block_reader_if.sv - Wishbone B4 bus bundle between wb_block_reader and its slave
interface wb_block_reader_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_block_reader.sv
// rtl/wb_block_reader.sv - Wishbone block reader feeding a ready/valid stream FIFO
// Define WB_BURST_EN for registered-feedback incrementing bursts; otherwise classic cycles only.
module wb_block_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  wb_block_reader_if.master wb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LAST_FREE   = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

  state_t           state;
  logic [31:0]      adr_q;
  logic [LEN_W-1:0] rem_q;
  logic             cyc_q, stb_q, busy_q, done_q;
  logic [2:0]       cti_q;
  logic [2:0]       cti_start, cti_next;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             push, pop, has_space;

  // stb is only ever high in REQ, so gating with it rejects stray acks
  assign push       = stb_q & wb.wb_ack_i;
  assign rd_valid_o = (fifo_cnt != '0);
  assign pop        = rd_valid_o & rd_ready_i;
  assign has_space  = (fifo_cnt < DEPTH_CNT);
  assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : 32'h0;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = 32'h0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_cti_o = cti_q;
  assign wb.wb_bte_o = 2'b00;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = 1'b0;

`ifdef WB_BURST_EN
  logic [LEN_W-1:0] issue_rem;
  logic [AW:0]      cnt_after;

  // A word ends the burst if it is the block's last or could fill the FIFO
  always_comb begin
    issue_rem = (state == IDLE) ? len_i : rem_q;
    cnt_after = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    cti_start = (issue_rem == LEN_W'(1) || fifo_cnt >= LAST_FREE) ? 3'b111 : 3'b010;
    cti_next  = (rem_q == LEN_W'(2) || cnt_after >= LAST_FREE) ? 3'b111 : 3'b010;
  end
`else
  assign cti_start = CTI_CLASSIC;
  assign cti_next  = CTI_CLASSIC;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wb.wb_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      adr_q  <= 32'h0;
      rem_q  <= '0;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      cti_q  <= CTI_CLASSIC;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              adr_q  <= base_adr_i & 32'hFFFF_FFFC;
              rem_q  <= len_i;
              busy_q <= 1'b1;
              if (has_space) begin
                state <= REQ;
                cyc_q <= 1'b1;
                stb_q <= 1'b1;
                cti_q <= cti_start;
              end else begin
                state <= HOLD;
              end
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (push) begin
            adr_q <= adr_q + 32'd4;
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state  <= DONE;
              cyc_q  <= 1'b0;
              stb_q  <= 1'b0;
              cti_q  <= CTI_CLASSIC;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (fifo_cnt == LAST_FREE && !pop) begin
              state <= HOLD;
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              cti_q <= CTI_CLASSIC;
            end else begin
              cti_q <= cti_next;
            end
          end
        end
        HOLD: begin
          if (has_space) begin
            state <= REQ;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            cti_q <= cti_start;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_block_reader.sv
// tb/tb_wb_block_reader.sv - self-checking bench for wb_block_reader with a ROM-style WB slave
module tb_wb_block_reader;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base = 32'h0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, rd_valid;
  logic [31:0]      rd_data;
  logic             rd_ready = 1'b0;
  logic             slave_ack = 1'b0;
  logic             stray_ack = 1'b0;
  logic [31:0]      slave_dat = 32'h0;
  bit               slow = 1'b0;

  int checks = 0;
  int passed = 0;
  int acks = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] adr_log[$];
  logic [2:0]  cti_log[$];

  typedef struct {
    logic [31:0]      base;
    logic [LEN_W-1:0] len;
    logic [31:0]      first_adr;
    logic [31:0]      last_adr;
    int               n_acks;
  } vec_t;
  vec_t vecs[4];

  wb_block_reader_if bus();
  assign bus.wb_ack_i = slave_ack | stray_ack;
  assign bus.wb_dat_i = slave_dat;

  wb_block_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .base_adr_i (base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  // Registered-ack slave: ack is negated for at least one cycle between words
  always @(posedge clk) begin
    if (rst) slave_ack <= 1'b0;
    else if (bus.wb_cyc_o && bus.wb_stb_o && !slave_ack && (!slow || $urandom_range(0, 2) != 0)) begin
      slave_ack <= 1'b1;
      slave_dat <= rom(bus.wb_adr_o);
    end else slave_ack <= 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'd1, 32'd0);
      else check("sb_data", rd_data, exp_q.pop_front());
    end
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      acks++;
      adr_log.push_back(bus.wb_adr_o);
      cti_log.push_back(bus.wb_cti_o);
    end
    if (done) begin
      done_cnt++;
      check("done_busy_low", 32'(busy), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acks = 0;
    done_cnt = 0;
    adr_log.delete();
    cti_log.delete();
  endtask

  task automatic launch(input logic [31:0] b, input logic [LEN_W-1:0] n, input bit accept);
    logic [31:0] a;
    tick();
    start = 1'b1;
    base  = b;
    len   = n;
    a = {b[31:2], 2'b00};
    if (accept) for (int k = 0; k < int'(n); k++) exp_q.push_back(rom(a + 32'(4 * k)));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("timeout_done", 32'd0, 32'd1);
    for (int k = 0; k < 64 && rd_valid; k++) tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ea[4];
    logic [2:0]  ec[3];

    vecs[0] = '{32'h0000_0203, 16'd3,  32'h0000_0200, 32'h0000_0208, 3};
    vecs[1] = '{32'h0000_0040, 16'd1,  32'h0000_0040, 32'h0000_0040, 1};
    vecs[2] = '{32'h0000_1000, 16'd20, 32'h0000_1000, 32'h0000_104C, 20};
    vecs[3] = '{32'h7FFF_FFFC, 16'd2,  32'h7FFF_FFFC, 32'h8000_0000, 2};

    repeat (3) tick();
    @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
    check("rst_stb",   32'(bus.wb_stb_o), 32'd0);
    check("rst_adr",   bus.wb_adr_o, 32'h0);
    check("rst_cti",   32'(bus.wb_cti_o), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data",  rd_data, 32'h0);
    check("tie_sel",   32'(bus.wb_sel_o), 32'hF);
    check("tie_we",    32'(bus.wb_we_o), 32'd0);
    tick();
    rst = 1'b0;

    // T1: ROM words A0..A3 from 0x100
    slow = 1'b0; rd_ready = 1'b1; clear_logs();
    ea[0] = 32'h100; ea[1] = 32'h104; ea[2] = 32'h108; ea[3] = 32'h10C;
    launch(32'h100, 16'd4, 1'b1);
    wait_done(200);
    for (int k = 0; k < 4; k++) check("t1_adr", adr_log[k], ea[k]);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // T4: address wraps past 2^32
    clear_logs();
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0; ea[3] = 32'h4;
    launch(32'hFFFF_FFF8, 16'd4, 1'b1);
    wait_done(200);
    for (int k = 0; k < 4; k++) check("t4_adr", adr_log[k], ea[k]);

    for (int i = 0; i < 4; i++) begin
      slow = (i % 2 == 1);
      rd_ready = 1'b1;
      clear_logs();
      launch(vecs[i].base, vecs[i].len, 1'b1);
      wait_done(1000);
      check("vec_acks",      32'(acks), 32'(vecs[i].n_acks));
      check("vec_first_adr", adr_log[0], vecs[i].first_adr);
      check("vec_last_adr",  adr_log[adr_log.size() - 1], vecs[i].last_adr);
      check("vec_done_cnt",  32'(done_cnt), 32'd1);
      check("vec_sb_empty",  32'(exp_q.size()), 32'd0);
      check("vec_busy",      32'(busy), 32'd0);
    end

    // T2: FIFO back-pressure stops the bus after 16 words; a start while busy is dropped
    slow = 1'b0; rd_ready = 1'b0; clear_logs();
    launch(32'h2000, 16'd40, 1'b1);
    repeat (120) tick();
    check("t2_acks_full", 32'(acks), 32'd16);
    check("t2_cyc_low",   32'(bus.wb_cyc_o), 32'd0);
    check("t2_busy",      32'(busy), 32'd1);
    check("t2_valid",     32'(rd_valid), 32'd1);
`ifdef WB_BURST_EN
    check("t2_cti_eob", 32'(cti_log[15]), 32'd7);
`else
    check("t2_cti_classic", 32'(cti_log[15]), 32'd0);
`endif
    launch(32'h9000, 16'd5, 1'b0);
    repeat (10) tick();
    check("t2_drop_start", 32'(acks), 32'd16);
    rd_ready = 1'b1;
    wait_done(1000);
    check("t2_acks_all",  32'(acks), 32'd40);
    check("t2_done_cnt",  32'(done_cnt), 32'd1);
    check("t2_sb_empty",  32'(exp_q.size()), 32'd0);

    // T3: zero-length start
    clear_logs();
    launch(32'h500, 16'd0, 1'b1);
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_cyc",  32'(bus.wb_cyc_o), 32'd0);
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_no_acks",    32'(acks), 32'd0);

    // stray ack while idle must not push
    tick(); stray_ack = 1'b1; tick(); stray_ack = 1'b0;
    @(negedge clk);
    check("stray_valid", 32'(rd_valid), 32'd0);

    // T5: reset mid-block
    slow = 1'b1; rd_ready = 1'b0; clear_logs();
    launch(32'h3000, 16'd10, 1'b1);
    for (int k = 0; k < 300 && acks < 3; k++) tick();
    check("t5_stb_before", 32'(bus.wb_stb_o), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t5_cyc",   32'(bus.wb_cyc_o), 32'd0);
    check("t5_stb",   32'(bus.wb_stb_o), 32'd0);
    check("t5_valid", 32'(rd_valid), 32'd0);
    check("t5_busy",  32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    rd_ready = 1'b1; clear_logs();
    launch(32'h3000, 16'd3, 1'b1);
    wait_done(500);
    check("t5_restart_acks", 32'(acks), 32'd3);
    check("t5_restart_adr",  adr_log[0], 32'h3000);
    check("t5_sb_empty",     32'(exp_q.size()), 32'd0);

    // T6: cycle type sequence
    slow = 1'b0; rd_ready = 1'b1; clear_logs();
`ifdef WB_BURST_EN
    ec[0] = 3'b010; ec[1] = 3'b010; ec[2] = 3'b111;
`else
    ec[0] = 3'b000; ec[1] = 3'b000; ec[2] = 3'b000;
`endif
    launch(32'h600, 16'd3, 1'b1);
    wait_done(200);
    for (int k = 0; k < 3; k++) check("t6_cti", 32'(cti_log[k]), 32'(ec[k]));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
